// File: rtl/guess_game_pkg.sv
// Shared types, widths and helpers for the number-guessing game core.
package guess_game_pkg;

   localparam int N       = 10;  // switches, LEDs and possible values
   localparam int CNT_W   = 4;   // counter / value index width
   localparam int TRIES_W = 2;   // wrong-guess counter width
   localparam int TIMER_W = 4;   // result display hold timer width

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      WIN,
      LOSE
   } state_e;

   // Bits that can still hold the secret after a wrong guess:
   // everything above the guess if the secret is larger, else everything below.
   function automatic logic [N-1:0] hint_mask(input logic [CNT_W-1:0] guess,
                                              input logic [CNT_W-1:0] secret);
      logic [N-1:0] m;
      m = '0;
      for (int i = 0; i < N; i++) begin
         if (secret > guess) begin
            m[i] = (CNT_W'(i) > guess);
         end else begin
            m[i] = (CNT_W'(i) < guess);
         end
      end
      return m;
   endfunction

   // One-hot LED pattern for a value index.
   function automatic logic [N-1:0] onehot(input logic [CNT_W-1:0] idx);
      logic [N-1:0] one;
      one = {{(N-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

endpackage

// File: rtl/guess_decode.sv
// Switch-guess decoder: flags a single set bit and encodes its position.
module guess_decode
   import guess_game_pkg::*;
(
   input  logic [N-1:0]     g,
   output logic             valid_onehot,
   output logic [CNT_W-1:0] idx
);

   logic [CNT_W-1:0] cnt;

   // Count set bits and OR together their positions; idx is meaningful only when exactly one is set.
   always_comb begin
      cnt = '0;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (g[i]) begin
            cnt = cnt + 1'b1;
            idx = idx | CNT_W'(i);
         end
      end
      valid_onehot = (cnt == CNT_W'(1));
   end

endmodule

// File: rtl/guess_game.sv
// Number-guessing game core: free-running mod-N counter picks the secret on
// the first guess, wrong guesses narrow an LED hint mask, results are held
// on the LEDs for a fixed number of cycles before returning to idle.
module guess_game
   import guess_game_pkg::*;
#(
   parameter int MAX_TRIES     = 3,
   parameter int RESULT_CYCLES = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] G,
   output logic         wrong,
   output logic [N-1:0] LED
);

   state_e             state_q,   state_d;
   logic [CNT_W-1:0]   counter_q, counter_d;
   logic [CNT_W-1:0]   secret_q,  secret_d;
   logic [TRIES_W-1:0] tries_q,   tries_d;
   logic [N-1:0]       mask_q,    mask_d;
   logic [TIMER_W-1:0] timer_q,   timer_d;
   logic [N-1:0]       led_q,     led_d;
   logic               wrong_q,   wrong_d;
   logic [N-1:0]       g_q;

   logic               g_onehot;
   logic [CNT_W-1:0]   g_idx;
   logic               take_guess;
   logic [CNT_W-1:0]   judge_secret;
   logic [TRIES_W-1:0] tries_inc;
   logic [N-1:0]       mask_hint;

   guess_decode u_decode (
      .g            (G),
      .valid_onehot (g_onehot),
      .idx          (g_idx)
   );

   // A guess counts only on the rising edge of a single switch out of all-off.
   assign take_guess = (g_q == '0) && g_onehot;

   // Next-state, counter, mask, timer and output computation.
   always_comb begin
      state_d   = state_q;
      secret_d  = secret_q;
      tries_d   = tries_q;
      mask_d    = mask_q;
      timer_d   = timer_q;
      led_d     = led_q;
      wrong_d   = wrong_q;
      counter_d = (counter_q == CNT_W'(N - 1)) ? '0 : counter_q + 1'b1;

      // The first guess of a round is judged against the counter it latches.
      judge_secret = (state_q == IDLE) ? counter_q : secret_q;
      tries_inc    = tries_q + 1'b1;
      mask_hint    = mask_q & hint_mask(g_idx, judge_secret);

      case (state_q)
         IDLE, PLAY: begin
            if (state_q == IDLE) begin
               led_d   = '0;
               wrong_d = 1'b0;
            end
            if (take_guess) begin
               secret_d = judge_secret;
               // A correct guess wins before the try count is looked at.
               if (g_idx == judge_secret) begin
                  state_d = WIN;
                  led_d   = onehot(judge_secret);
                  wrong_d = 1'b0;
                  timer_d = '0;
               end else begin
                  tries_d = tries_inc;
                  mask_d  = mask_hint;
                  wrong_d = 1'b1;
                  if (tries_inc == TRIES_W'(MAX_TRIES)) begin
                     state_d = LOSE;
                     led_d   = onehot(judge_secret);
                     timer_d = '0;
                  end else begin
                     state_d = PLAY;
                     led_d   = mask_hint;
                  end
               end
            end
         end
         WIN, LOSE: begin
            if (timer_q == TIMER_W'(RESULT_CYCLES - 1)) begin
               state_d = IDLE;
               led_d   = '0;
               wrong_d = 1'b0;
               tries_d = '0;
               mask_d  = '1;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         counter_q <= '0;
         secret_q  <= '0;
         tries_q   <= '0;
         mask_q    <= '1;
         timer_q   <= '0;
         led_q     <= '0;
         wrong_q   <= 1'b0;
         g_q       <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         secret_q  <= secret_d;
         tries_q   <= tries_d;
         mask_q    <= mask_d;
         timer_q   <= timer_d;
         led_q     <= led_d;
         wrong_q   <= wrong_d;
         g_q       <= G;
      end
   end

   assign LED   = led_q;
   assign wrong = wrong_q;

endmodule

// File: tb/tb_guess_game.sv
// Self-checking bench for guess_game: directed vector table, a hand-written
// mid-round reset sequence, and randomized play against a range-based model.
module tb_guess_game;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] G     = '0;
   logic [9:0] LED;
   logic       wrong;

   always #5 clk = ~clk;

   guess_game dut (
      .clk   (clk),
      .reset (reset),
      .G     (G),
      .wrong (wrong),
      .LED   (LED)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model: secret range [lo,hi] ----------------
   int         m_edges;
   int         m_hold;
   bit         m_in_round;
   int         m_secret;
   int         m_miss;
   int         m_lo;
   int         m_hi;
   logic [9:0] m_gprev;
   logic [9:0] m_led;
   bit         m_wrong;

   function automatic logic [9:0] range_mask(int lo, int hi);
      logic [9:0] r;
      for (int i = 0; i < 10; i++) r[i] = (i >= lo) && (i <= hi);
      return r;
   endfunction

   task automatic model_reset();
      m_edges = 0; m_hold = 0; m_in_round = 0; m_secret = 0; m_miss = 0;
      m_lo = 0; m_hi = 9; m_gprev = '0; m_led = '0; m_wrong = 0;
   endtask

   task automatic model_step(input logic [9:0] g);
      int cnt;
      int gi;
      cnt = m_edges % 10;
      if (m_hold > 0) begin
         m_hold--;
         if (m_hold == 0) begin
            m_led = '0; m_wrong = 0; m_in_round = 0; m_miss = 0; m_lo = 0; m_hi = 9;
         end
      end else if (m_gprev == 0 && $countones(g) == 1) begin
         gi = 0;
         for (int i = 0; i < 10; i++) if (g[i]) gi = i;
         if (!m_in_round) begin
            m_in_round = 1;
            m_secret   = cnt;
         end
         if (gi == m_secret) begin
            m_led = 10'(1) << m_secret; m_wrong = 0; m_hold = 8;
         end else begin
            m_miss++;
            if (m_secret > gi) m_lo = (gi + 1 > m_lo) ? gi + 1 : m_lo;
            else               m_hi = (gi - 1 < m_hi) ? gi - 1 : m_hi;
            m_wrong = 1;
            if (m_miss == 3) begin
               m_led = 10'(1) << m_secret; m_hold = 8;
            end else begin
               m_led = range_mask(m_lo, m_hi);
            end
         end
      end
      m_gprev = g;
      m_edges++;
   endtask

   // ---------------- checking and driving ----------------
   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apply_reset();
      G     = '0;
      reset = 1'b0;
      model_reset();
      #2;
      check("rst_led", LED, 10'h000);
      check("rst_wrong", {9'b0, wrong}, 10'h000);
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic step(input logic [9:0] g);
      G = g;
      @(posedge clk);
      model_step(g);
      #1;
   endtask

   typedef struct {
      bit         do_rst;
      logic [9:0] g;
      logic [9:0] led;
      bit         wrong;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit r, input logic [9:0] g, input logic [9:0] led, input bit w, input int n);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.do_rst = r && (i == 0);
         v.g      = g;
         v.led    = led;
         v.wrong  = w;
         vecs.push_back(v);
      end
   endtask

   initial begin
      logic [9:0] gr;
      int         r;

      // Win on first guess: secret 9 at edge 10, held for 8 cycles.
      add(1, 10'h000, 10'h000, 0, 1);
      add(0, 10'h000, 10'h000, 0, 8);
      add(0, 10'h200, 10'h200, 0, 1);
      add(0, 10'h000, 10'h200, 0, 7);
      add(0, 10'h000, 10'h000, 0, 1);
      // Hint narrowing then win: secret 4.
      add(1, 10'h000, 10'h000, 0, 1);
      add(0, 10'h000, 10'h000, 0, 3);
      add(0, 10'h200, 10'h1FF, 1, 1);
      add(0, 10'h000, 10'h1FF, 1, 1);
      add(0, 10'h002, 10'h1FC, 1, 1);
      add(0, 10'h000, 10'h1FC, 1, 1);
      add(0, 10'h010, 10'h010, 0, 1);
      add(0, 10'h000, 10'h010, 0, 7);
      add(0, 10'h000, 10'h000, 0, 1);
      // Loss after three misses: secret 4, guesses 9, 1, 0.
      add(1, 10'h000, 10'h000, 0, 1);
      add(0, 10'h000, 10'h000, 0, 3);
      add(0, 10'h200, 10'h1FF, 1, 1);
      add(0, 10'h000, 10'h1FF, 1, 1);
      add(0, 10'h002, 10'h1FC, 1, 1);
      add(0, 10'h000, 10'h1FC, 1, 1);
      add(0, 10'h001, 10'h010, 1, 1);
      add(0, 10'h000, 10'h010, 1, 7);
      add(0, 10'h000, 10'h000, 0, 1);
      // Multi-bit input ignored; a held switch counts once.
      add(1, 10'h003, 10'h000, 0, 3);
      add(0, 10'h000, 10'h000, 0, 1);
      add(0, 10'h200, 10'h1FF, 1, 3);
      add(0, 10'h000, 10'h1FF, 1, 1);
      add(0, 10'h010, 10'h010, 0, 1);
      // Counter wrap: first guess at edge 11 sees secret 0.
      add(1, 10'h000, 10'h000, 0, 1);
      add(0, 10'h000, 10'h000, 0, 9);
      add(0, 10'h001, 10'h001, 0, 1);

      #1;
      foreach (vecs[i]) begin
         if (vecs[i].do_rst) apply_reset();
         step(vecs[i].g);
         check($sformatf("vec%0d_led", i), LED, vecs[i].led);
         check($sformatf("vec%0d_wrong", i), {9'b0, wrong}, {9'b0, vecs[i].wrong});
      end

      // Reset in the middle of a round, then the counter restarts at 0.
      apply_reset();
      repeat (4) step(10'h000);
      step(10'h200);
      check("mid_play_wrong", {9'b0, wrong}, 10'h001);
      check("mid_play_led", LED, 10'h1FF);
      #2;
      apply_reset();
      step(10'h001);
      check("restart_win_led", LED, 10'h001);
      check("restart_win_wrong", {9'b0, wrong}, 10'h000);

      // Randomized play against the model, with occasional resets.
      apply_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 399) == 0) apply_reset();
         r = $urandom_range(0, 9);
         if (r < 4)       gr = '0;
         else if (r < 8)  gr = 10'(1) << $urandom_range(0, 9);
         else if (r < 9)  gr = 10'($urandom_range(0, 1023));
         else             gr = G;
         step(gr);
         check("rnd_led", LED, m_led);
         check("rnd_wrong", {9'b0, wrong}, {9'b0, m_wrong});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
